// File: rtl/retry_req_initiator.sv
// retry_req_initiator
// Requester-side node of the retry protocol. Local commands are buffered in
// ENTRY_NUM slots and issued one at a time to the retry engine. A first try
// goes out with req_type=1 (retry allowed). If the engine answers with a retry
// ack, the slot parks in RWAIT until a credit grant addressed to NODE_ID
// arrives. The slot is then reissued with req_type=0 (credited).
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   vld_cmd_in / rdy_cmd_in            local command handshake
//   cmd_qos, cmd_payload               command contents, captured on handshake
//   vld_req_out / rdy_req_out          request handshake towards the engine
//   req_type, qos_type, src_id,
//   payload_out                        request contents (held while valid)
//   vld_ack_in, ack_retry              ack for the single outstanding request
//   vld_grant_in, grant_des_id,
//   rdy_grant_out                      retry credit grant handshake
//   outstanding                        number of non-FREE slots
//   proto_err                          sticky: retry ack on a credited request
module retry_req_initiator #(
    parameter int NODE_ID    = 0,
    parameter int SRC_NODE_W = 4,
    parameter int ENTRY_NUM  = 4,
    parameter int PAYLD_BW   = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           vld_cmd_in,
    output logic                           rdy_cmd_in,
    input  logic [3:0]                     cmd_qos,
    input  logic [PAYLD_BW-1:0]            cmd_payload,
    output logic                           vld_req_out,
    input  logic                           rdy_req_out,
    output logic                           req_type,
    output logic [3:0]                     qos_type,
    output logic [SRC_NODE_W-1:0]          src_id,
    output logic [PAYLD_BW-1:0]            payload_out,
    input  logic                           vld_ack_in,
    input  logic                           ack_retry,
    input  logic                           vld_grant_in,
    input  logic [SRC_NODE_W-1:0]          grant_des_id,
    output logic                           rdy_grant_out,
    output logic [$clog2(ENTRY_NUM+1)-1:0] outstanding,
    output logic                           proto_err
);

    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = $clog2(ENTRY_NUM + 1);
    localparam int AGE_W = 4;
    localparam logic [AGE_W-1:0]      AGE_MAX   = {AGE_W{1'b1}};
    localparam logic [SRC_NODE_W-1:0] NODE_ID_C = SRC_NODE_W'(NODE_ID);

    typedef enum logic [2:0] {
        S_FREE    = 3'd0,
        S_NEW     = 3'd1,
        S_SENT    = 3'd2,
        S_RWAIT   = 3'd3,
        S_GRANTED = 3'd4
    } slot_state_e;

    slot_state_e         state_q [ENTRY_NUM];
    slot_state_e         state_d [ENTRY_NUM];
    logic [PAYLD_BW-1:0] pay_q   [ENTRY_NUM];
    logic [PAYLD_BW-1:0] pay_d   [ENTRY_NUM];
    logic [3:0]          qos_q   [ENTRY_NUM];
    logic [3:0]          qos_d   [ENTRY_NUM];
    logic [AGE_W-1:0]    age_q   [ENTRY_NUM];
    logic [AGE_W-1:0]    age_d   [ENTRY_NUM];

    // req_type of the request currently in SENT, used to flag protocol errors
    logic                sent_type_q, sent_type_d;
    logic                proto_err_q, proto_err_d;
    logic                vld_req_q, vld_req_d;
    logic [IDX_W-1:0]    req_idx_q, req_idx_d;
    logic                req_type_q, req_type_d;
    logic [3:0]          qos_out_q, qos_out_d;
    logic [PAYLD_BW-1:0] payload_out_q, payload_out_d;
    logic                rdy_cmd_q, rdy_cmd_d;
    logic [CNT_W-1:0]    outstanding_q, outstanding_d;

    logic                any_free_s, any_sent_s, any_new_s, any_granted_s, any_rwait_s;
    logic [IDX_W-1:0]    free_idx_s, sent_idx_s, new_idx_s, granted_idx_s, oldest_idx_s;
    logic [AGE_W-1:0]    oldest_age_s;
    logic                cmd_hs_s, req_hs_s, ack_take_s, grant_hs_s;
    logic                sel_ok_s;

    // Per-class slot decode: lowest index per state, oldest RWAIT slot
    always_comb begin
        any_free_s    = 1'b0;
        any_sent_s    = 1'b0;
        any_new_s     = 1'b0;
        any_granted_s = 1'b0;
        free_idx_s    = '0;
        sent_idx_s    = '0;
        new_idx_s     = '0;
        granted_idx_s = '0;
        // Walk downwards so the last hit is the lowest index
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            free_idx_s    = (state_q[i] == S_FREE)    ? IDX_W'(i) : free_idx_s;
            sent_idx_s    = (state_q[i] == S_SENT)    ? IDX_W'(i) : sent_idx_s;
            new_idx_s     = (state_q[i] == S_NEW)     ? IDX_W'(i) : new_idx_s;
            granted_idx_s = (state_q[i] == S_GRANTED) ? IDX_W'(i) : granted_idx_s;
            any_free_s    = any_free_s    | (state_q[i] == S_FREE);
            any_sent_s    = any_sent_s    | (state_q[i] == S_SENT);
            any_new_s     = any_new_s     | (state_q[i] == S_NEW);
            any_granted_s = any_granted_s | (state_q[i] == S_GRANTED);
        end
        any_rwait_s  = 1'b0;
        oldest_idx_s = '0;
        oldest_age_s = '0;
        // Strictly greater age wins, so saturated ties fall to the lowest index
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if ((state_q[i] == S_RWAIT) && (!any_rwait_s || (age_q[i] > oldest_age_s))) begin
                oldest_idx_s = IDX_W'(i);
                oldest_age_s = age_q[i];
            end else begin
                oldest_idx_s = oldest_idx_s;
            end
            any_rwait_s = any_rwait_s | (state_q[i] == S_RWAIT);
        end
    end

    assign cmd_hs_s      = vld_cmd_in & rdy_cmd_q;
    assign req_hs_s      = vld_req_q & rdy_req_out;
    assign ack_take_s    = vld_ack_in & any_sent_s;
    assign rdy_grant_out = vld_grant_in & (grant_des_id == NODE_ID_C) & any_rwait_s;
    assign grant_hs_s    = rdy_grant_out;
    assign sel_ok_s      = ~vld_req_q & ~any_sent_s;

    // Slot transitions and issue register; each event touches a distinct slot
    always_comb begin
        state_d       = state_q;
        pay_d         = pay_q;
        qos_d         = qos_q;
        age_d         = age_q;
        sent_type_d   = sent_type_q;
        proto_err_d   = proto_err_q;
        vld_req_d     = vld_req_q;
        req_idx_d     = req_idx_q;
        req_type_d    = req_type_q;
        qos_out_d     = qos_out_q;
        payload_out_d = payload_out_q;

        for (int i = 0; i < ENTRY_NUM; i++) begin
            if ((state_q[i] == S_RWAIT) && (age_q[i] != AGE_MAX)) begin
                age_d[i] = age_q[i] + {{(AGE_W-1){1'b0}}, 1'b1};
            end else begin
                age_d[i] = age_q[i];
            end
        end

        if (cmd_hs_s) begin
            state_d[free_idx_s] = S_NEW;
            pay_d[free_idx_s]   = cmd_payload;
            qos_d[free_idx_s]   = cmd_qos;
        end else begin
            state_d[free_idx_s] = state_d[free_idx_s];
        end

        if (req_hs_s) begin
            state_d[req_idx_q] = S_SENT;
            sent_type_d        = req_type_q;
            vld_req_d          = 1'b0;
            req_type_d         = 1'b0;
            qos_out_d          = 4'd0;
            payload_out_d      = '0;
        end else if (sel_ok_s && any_granted_s) begin
            vld_req_d     = 1'b1;
            req_idx_d     = granted_idx_s;
            req_type_d    = 1'b0;
            qos_out_d     = qos_q[granted_idx_s];
            payload_out_d = pay_q[granted_idx_s];
        end else if (sel_ok_s && any_new_s) begin
            vld_req_d     = 1'b1;
            req_idx_d     = new_idx_s;
            req_type_d    = 1'b1;
            qos_out_d     = qos_q[new_idx_s];
            payload_out_d = pay_q[new_idx_s];
        end else begin
            vld_req_d = vld_req_q;
        end

        if (ack_take_s) begin
            if (ack_retry) begin
                state_d[sent_idx_s] = S_RWAIT;
                age_d[sent_idx_s]   = '0;
                proto_err_d         = proto_err_q | ~sent_type_q;
            end else begin
                state_d[sent_idx_s] = S_FREE;
            end
        end else begin
            proto_err_d = proto_err_d;
        end

        if (grant_hs_s) begin
            state_d[oldest_idx_s] = S_GRANTED;
        end else begin
            state_d[oldest_idx_s] = state_d[oldest_idx_s];
        end
    end

    // Occupancy and command-ready derived from the next slot state
    always_comb begin
        outstanding_d = '0;
        rdy_cmd_d     = 1'b0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            outstanding_d = outstanding_d + ((state_d[i] != S_FREE) ? CNT_W'(1) : CNT_W'(0));
            rdy_cmd_d     = rdy_cmd_d | (state_d[i] == S_FREE);
        end
    end

    // State register; reset drops every slot immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                state_q[i] <= S_FREE;
                pay_q[i]   <= '0;
                qos_q[i]   <= 4'd0;
                age_q[i]   <= '0;
            end
            sent_type_q   <= 1'b0;
            proto_err_q   <= 1'b0;
            vld_req_q     <= 1'b0;
            req_idx_q     <= '0;
            req_type_q    <= 1'b0;
            qos_out_q     <= 4'd0;
            payload_out_q <= '0;
            rdy_cmd_q     <= 1'b1;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            pay_q         <= pay_d;
            qos_q         <= qos_d;
            age_q         <= age_d;
            sent_type_q   <= sent_type_d;
            proto_err_q   <= proto_err_d;
            vld_req_q     <= vld_req_d;
            req_idx_q     <= req_idx_d;
            req_type_q    <= req_type_d;
            qos_out_q     <= qos_out_d;
            payload_out_q <= payload_out_d;
            rdy_cmd_q     <= rdy_cmd_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign rdy_cmd_in  = rdy_cmd_q;
    assign vld_req_out = vld_req_q;
    assign req_type    = req_type_q;
    assign qos_type    = qos_out_q;
    assign payload_out = payload_out_q;
    assign src_id      = NODE_ID_C;
    assign outstanding = outstanding_q;
    assign proto_err   = proto_err_q;

endmodule
